servo_pwm_decoder: RTL and testbench

Receive-side counterpart of the servo PWM generator. It samples an external servo-style PWM line and measures each high pulse in clock cycles. It converts the width back to a `resolution`-bit position using the same min/max pulse mapping the generator uses, and reports signal presence. It sits beside the servo output path, for loopback self-test of the generator and for decoding RC receiver inputs.

---
 rtl/servo_pwm_decoder_pkg.sv | 17 +
 rtl/servo_pwm_decoder_divider.sv | 61 ++++++
 rtl/servo_pwm_decoder.sv | 160 ++++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/servo_pwm_decoder_pkg.sv
// Shared servo PWM definitions: decoder FSM states and the microsecond-to-cycle
// conversion used by both the generator and the decoder.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HIGH,
    DIVIDE
  } state_t;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return us * (clk_hz / 1_000_000);
  endfunction

endpackage

// File: rtl/servo_pwm_decoder_divider.sv
// Restoring divider by a fixed constant: quotient = floor((dividend << RES) / DIVISOR),
// one quotient bit per cycle MSB first; done rises RES+1 cycles after start.
module pwm_seq_divider #(
  parameter int unsigned RES     = 8,
  parameter int unsigned DIVISOR = 1000,
  parameter int unsigned DW      = $clog2(DIVISOR + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  output logic          done,
  output logic [RES:0]  quotient
);

  localparam int unsigned RW = $clog2(2 * DIVISOR + 1);
  localparam int unsigned NW = $clog2(RES + 2);

  logic [RW-1:0] rem;
  logic [RW-1:0] cur;
  logic [RW-1:0] diff;
  logic [RW-1:0] rem_next;
  logic [NW-1:0] count;
  logic          busy;
  logic          take;

  // The dividend never exceeds DIVISOR, so every partial remainder stays below 2*DIVISOR.
  always_comb begin
    cur      = start ? RW'(dividend) : rem;
    take     = (cur >= RW'(DIVISOR));
    diff     = take ? (cur - RW'(DIVISOR)) : cur;
    rem_next = {diff[RW-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= rem_next;
        quotient <= {RES'(0), take};
        count    <= NW'(RES);
        busy     <= 1'b1;
      end else if (busy) begin
        rem      <= rem_next;
        quotient <= {quotient[RES-1:0], take};
        count    <= count - 1'b1;
        if (count == NW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures each high pulse in clock cycles and maps it back to a
// position with the generator's min/max pulse mapping, plus signal-presence tracking.
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int unsigned clk_hz       = 125_000_000,
  parameter int unsigned min_pulse_us = 1000,
  parameter int unsigned max_pulse_us = 2000,
  parameter int unsigned resolution   = 8,
  parameter int unsigned timeout_us   = 25000,
  localparam int unsigned TO_CYC      = us_to_cycles(clk_hz, timeout_us),
  localparam int unsigned CW          = $clog2(TO_CYC + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pwm_in,
  output logic [resolution-1:0] position,
  output logic                  valid,
  output logic                  range_err,
  output logic                  locked,
  output logic [CW-1:0]         width_cycles
);

  localparam int unsigned MIN_CYC = us_to_cycles(clk_hz, min_pulse_us);
  localparam int unsigned MAX_CYC = us_to_cycles(clk_hz, max_pulse_us);
  localparam int unsigned SPAN    = MAX_CYC - MIN_CYC;
  localparam int unsigned DW      = $clog2(SPAN + 1);

  if (MAX_CYC <= MIN_CYC) begin : g_bad_span
    $error("servo_pwm_decoder: max pulse must be longer than min pulse");
  end

  state_t              state;
  state_t              next_state;
  logic                sync1;
  logic                pwm_s;
  logic                pwm_d;
  logic [1:0]          prime;
  logic                rise;
  logic                fall;
  logic [CW-1:0]       width_cnt;
  logic [CW-1:0]       width_lat;
  logic [CW-1:0]       per_cnt;
  logic                per_timeout;
  logic                hi_timeout;
  logic                cnt_clear;
  logic                cnt_inc;
  logic                div_start;
  logic                div_done;
  logic                out_load;
  logic                rerr_lat;
  logic [DW-1:0]       dividend;
  logic [resolution:0] quotient;
  logic [31:0]         cnt_ext;
  logic [31:0]         lat_ext;

  // prime holds IDLE until the synchronizer carries real input, so a pulse already
  // high when reset releases is never mistaken for a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
      prime <= '0;
    end else begin
      sync1 <= pwm_in;
      pwm_s <= sync1;
      pwm_d <= pwm_s;
      prime <= {prime[0], 1'b1};
    end
  end

  assign rise = pwm_s & ~pwm_d;
  assign fall = ~pwm_s & pwm_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (prime[1] && !pwm_s) next_state = ARMED;
      ARMED:   if (rise) next_state = HIGH;
      HIGH:    if (fall) next_state = DIVIDE;
               else if (hi_timeout) next_state = IDLE;
      DIVIDE:  if (div_done) next_state = pwm_s ? IDLE : ARMED;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cnt_clear  = (state == ARMED) && rise;
    hi_timeout = (state == HIGH) && pwm_s && (width_cnt == CW'(TO_CYC));
    cnt_inc    = (state == HIGH) && pwm_s && !hi_timeout;
    div_start  = (state == HIGH) && fall;
    out_load   = (state == DIVIDE) && div_done;
  end

  // The counter starts at 1 because the edge cycle itself is already high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_cnt <= '0;
      width_lat <= '0;
      per_cnt   <= '0;
    end else begin
      if (cnt_clear)    width_cnt <= CW'(1);
      else if (cnt_inc) width_cnt <= width_cnt + 1'b1;
      if (div_start)    width_lat <= width_cnt;
      if (rise)         per_cnt   <= '0;
      else if (!per_timeout) per_cnt <= per_cnt + 1'b1;
    end
  end

  assign per_timeout = (per_cnt == CW'(TO_CYC));

  always_comb begin
    cnt_ext = 32'(width_cnt);
    lat_ext = 32'(width_lat);
    if (cnt_ext <= MIN_CYC)      dividend = '0;
    else if (cnt_ext >= MAX_CYC) dividend = DW'(SPAN);
    else                         dividend = DW'(cnt_ext - MIN_CYC);
    rerr_lat = (lat_ext < MIN_CYC) || (lat_ext > MAX_CYC);
  end

  pwm_seq_divider #(
    .RES     (resolution),
    .DIVISOR (SPAN),
    .DW      (DW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (dividend),
    .done     (div_done),
    .quotient (quotient)
  );

  // A full-span pulse yields exactly step_count, which saturates to the top code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position     <= '0;
      valid        <= 1'b0;
      range_err    <= 1'b0;
      width_cycles <= '0;
      locked       <= 1'b0;
    end else begin
      valid <= out_load;
      if (out_load) begin
        position     <= quotient[resolution] ? '1 : quotient[resolution-1:0];
        width_cycles <= width_lat;
        range_err    <= rerr_lat;
      end
      if (hi_timeout || per_timeout)  locked <= 1'b0;
      else if (out_load && !rerr_lat) locked <= 1'b1;
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Scoreboard bench for servo_pwm_decoder at 1 MHz: stimulus pushes hand-computed
// expectations, a negedge monitor pops one on every valid strobe.
module tb_servo_pwm_decoder;

  localparam int CW  = 15;
  localparam int LAT = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          pwm_in;
  logic [7:0]    position;
  logic          valid;
  logic          range_err;
  logic          locked;
  logic [CW-1:0] width_cycles;

  typedef struct {
    int          pos;
    int          width;
    int          rerr;
    int          lck;
    int unsigned fall;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  int unsigned cyc = 0;
  int unsigned last_rise = 0;

  int vec_w[4] = '{1000, 1750, 2000, 500};
  int vec_p[4] = '{0, 192, 255, 0};
  int vec_r[4] = '{0, 0, 0, 1};

  servo_pwm_decoder #(.clk_hz(1_000_000)) dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .position     (position),
    .valid        (valid),
    .range_err    (range_err),
    .locked       (locked),
    .width_cycles (width_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int high_len, input int low_len, input bit exp_valid,
                               input int pos, input int rerr, input int lck);
    exp_t e;
    pwm_in = 1'b1;
    last_rise = cyc;
    waitCycles(high_len);
    pwm_in = 1'b0;
    if (exp_valid) begin
      e.pos   = pos;
      e.width = high_len;
      e.rerr  = rerr;
      e.lck   = lck;
      e.fall  = cyc;
      sb.push_back(e);
    end
    waitCycles(low_len);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_position"}, int'(position), 0);
    checkOutput({tag, "_width"}, int'(width_cycles), 0);
    checkOutput({tag, "_range_err"}, int'(range_err), 0);
    checkOutput({tag, "_valid"}, int'(valid), 0);
    checkOutput({tag, "_locked"}, int'(locked), 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", int'(valid), 0);
        end else begin
          e = sb.pop_front();
          checkOutput("position", int'(position), e.pos);
          checkOutput("width_cycles", int'(width_cycles), e.width);
          checkOutput("range_err", int'(range_err), e.rerr);
          checkOutput("locked", int'(locked), e.lck);
          checkOutput("valid_latency", int'(cyc - e.fall), LAT);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    pwm_in = 1'b0;
    waitCycles(5);
    checkAllZero("reset");
    rst = 1'b0;
    waitCycles(20);

    // Nominal centre pulses, first one at the full 10000-cycle period.
    applyStimulus(1500, 8500, 1'b1, 128, 0, 1);
    applyStimulus(1500, 1000, 1'b1, 128, 0, 1);

    // Range endpoints, saturation and an under-range pulse (locked stays set).
    for (int i = 0; i < 4; i++)
      applyStimulus(vec_w[i], 1000, 1'b1, vec_p[i], vec_r[i], 1);

    // Reset in the middle of a pulse; its tail must not decode.
    pwm_in = 1'b1;
    waitCycles(700);
    rst = 1'b1;
    waitCycles(2);
    checkAllZero("midreset");
    rst = 1'b0;
    waitCycles(798);
    pwm_in = 1'b0;
    waitCycles(1000);
    applyStimulus(1500, 1000, 1'b1, 128, 0, 1);

    // Stuck-high input drops lock without a strobe.
    applyStimulus(25100, 1000, 1'b0, 0, 0, 0);
    checkOutput("stuck_high_locked", int'(locked), 0);

    // Rising edge during DIVIDE: second pulse discarded, the next one decodes.
    applyStimulus(1500, 5, 1'b1, 128, 0, 1);
    applyStimulus(1500, 1000, 1'b0, 0, 0, 0);
    applyStimulus(1500, 0, 1'b1, 128, 0, 1);

    // Input held low: lock lost about TO_CYC cycles after the last rise.
    waitCycles(int'(last_rise + 24990 - cyc));
    checkOutput("hold_low_still_locked", int'(locked), 1);
    waitCycles(30);
    checkOutput("hold_low_lock_lost", int'(locked), 0);

    for (int i = 0; i < 1000 && sb.size() != 0; i++) waitCycles(1);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
